// File: rtl/wait_gen_pkg.sv
// Shared definitions for the Z80 wait-state generator: register defaults,
// configuration field positions and the FSM state encoding.
package wait_gen_pkg;

  localparam logic [7:0] CFG_PORT_DEFAULT  = 8'hD2;
  localparam logic [7:0] CFG_RESET_DEFAULT = 8'b01_000_011;

  // Field layout of the configuration register: {io[1:0], ram[2:0], rom[2:0]}
  localparam int ROM_LSB = 0;
  localparam int RAM_LSB = 3;
  localparam int IO_LSB  = 6;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_STRETCH = 2'd1,
    ST_HOLD    = 2'd2
  } state_t;

endpackage

// File: rtl/wait_gen_counter.sv
// Three-bit load/decrement counter with a terminal flag raised when the
// count reaches one; it saturates at zero instead of wrapping.
module ws_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_load,
  input  logic [2:0] i_loadVal,
  input  logic       i_dec,
  output logic       o_terminal
);

  logic [2:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= 3'd0;
    end else if (i_load) begin
      r_count <= i_loadVal;
    end else if (i_dec && (r_count != 3'd0)) begin
      r_count <= r_count - 3'd1;
    end
  end

  assign o_terminal = (r_count == 3'd1);

endmodule

// File: rtl/wait_gen.sv
// Z80 wait-state generator: stretches ROM, RAM and I/O bus cycles by a
// programmable number of clocks held in an I/O-mapped configuration register.
module wait_gen
  import wait_gen_pkg::*;
#(
  parameter logic [7:0] CFG_PORT  = CFG_PORT_DEFAULT,
  parameter logic [7:0] CFG_RESET = CFG_RESET_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mreq_n,
  input  logic       iorq_n,
  input  logic       rd_n,
  input  logic       wr_n,
  input  logic       m1_n,
  input  logic       rfsh_n,
  input  logic       romen_n,
  input  logic       ramen_n,
  input  logic [7:0] a07,
  inout  wire  [7:0] data,
  output logic       wait_n
);

  state_t     r_state;
  state_t     w_nextState;
  logic [7:0] r_cfg;
  logic       r_wrPrev;
  logic       r_reqPrev;
  logic       r_waitN;

  logic       w_addrHit;
  logic       w_cfgWr;
  logic       w_cfgRd;
  logic       w_memReq;
  logic       w_ioReq;
  logic       w_req;
  logic       w_start;
  logic       w_busIdle;
  logic [2:0] w_waits;
  logic       w_load;
  logic       w_dec;
  logic       w_terminal;

  assign w_addrHit = (a07 == CFG_PORT);
  assign w_cfgWr   = !iorq_n && !wr_n && m1_n && w_addrHit;
  assign w_cfgRd   = !iorq_n && !rd_n && m1_n && w_addrHit;
  assign w_memReq  = !mreq_n && rfsh_n;
  assign w_ioReq   = !iorq_n && m1_n;
  assign w_req     = w_memReq || w_ioReq;
  assign w_start   = w_req && !r_reqPrev;
  assign w_busIdle = mreq_n && iorq_n;

  assign data   = w_cfgRd ? r_cfg : 8'bz;
  assign wait_n = r_waitN;

  // r_reqPrev resets high so a request already pending at release is ignored
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cfg     <= CFG_RESET;
      r_wrPrev  <= 1'b0;
      r_reqPrev <= 1'b1;
    end else begin
      r_wrPrev  <= w_cfgWr;
      r_reqPrev <= w_req;
      if (w_cfgWr && !r_wrPrev) begin
        r_cfg <= data;
      end
    end
  end

  always_comb begin
    w_waits = 3'd0;
    if (w_memReq) begin
      if (!romen_n) begin
        w_waits = r_cfg[ROM_LSB +: 3];
      end else if (!ramen_n) begin
        w_waits = r_cfg[RAM_LSB +: 3];
      end
    end else if (w_ioReq) begin
      w_waits = {1'b0, r_cfg[IO_LSB +: 2]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_waitN <= 1'b1;
    end else begin
      r_state <= w_nextState;
      r_waitN <= (w_nextState != ST_STRETCH);
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_load      = 1'b0;
    w_dec       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          if (w_waits != 3'd0) begin
            w_nextState = ST_STRETCH;
            w_load      = 1'b1;
          end else begin
            w_nextState = ST_HOLD;
          end
        end
      end
      ST_STRETCH: begin
        w_dec = 1'b1;
        if (w_busIdle) begin
          w_nextState = ST_IDLE;
        end else if (w_terminal) begin
          w_nextState = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (w_busIdle) begin
          w_nextState = ST_IDLE;
        end
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  ws_counter u_counter (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_loadVal  (w_waits),
    .i_dec      (w_dec),
    .o_terminal (w_terminal)
  );

endmodule

// File: tb/tb_wait_gen.sv
// Scoreboard bench for wait_gen: bus-cycle tasks queue the expected stretch
// length and read data; a negedge monitor measures each bus cycle and compares.
module tb_wait_gen;

  localparam int K_ROMRD = 0;
  localparam int K_RAMRD = 1;
  localparam int K_RAMWR = 2;
  localparam int K_IORD  = 3;
  localparam int K_IOWR  = 4;
  localparam int K_RFSH  = 5;
  localparam int K_INTA  = 6;

  logic       clk = 1'b0;
  logic       reset;
  logic       mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n, romen_n, ramen_n;
  logic [7:0] a07;
  wire  [7:0] data;
  wire        wait_n;
  logic       tbDrive;
  logic [7:0] tbData;

  int         nCompared = 0;
  int         nFailed   = 0;
  int         waitQ[$];
  logic [7:0] dataQ[$];

  int         lowCnt = 0;
  bit         inWin  = 1'b0;
  bit         seenRd = 1'b0;
  logic [7:0] rdVal  = 8'h00;

  always #5 clk = ~clk;

  assign data = tbDrive ? tbData : 8'bz;

  for (genvar i = 0; i < 8; i++) begin : g_pull
    pullup (data[i]);
  end

  wait_gen dut (
    .clk     (clk),
    .reset   (reset),
    .mreq_n  (mreq_n),
    .iorq_n  (iorq_n),
    .rd_n    (rd_n),
    .wr_n    (wr_n),
    .m1_n    (m1_n),
    .rfsh_n  (rfsh_n),
    .romen_n (romen_n),
    .ramen_n (ramen_n),
    .a07     (a07),
    .data    (data),
    .wait_n  (wait_n)
  );

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic applyIdle();
    mreq_n  = 1'b1; iorq_n  = 1'b1; rd_n    = 1'b1; wr_n   = 1'b1;
    m1_n    = 1'b1; rfsh_n  = 1'b1; romen_n = 1'b1; ramen_n = 1'b1;
    a07     = 8'h00; tbDrive = 1'b0; tbData = 8'h00;
  endtask

  // Write data is inverted after the first edge so a re-load would be visible
  task automatic busCycle(input int kind, input logic [7:0] addr, input logic [7:0] wdata, input int hold);
    @(posedge clk); #2;
    a07 = addr;
    case (kind)
      K_ROMRD: begin mreq_n = 1'b0; rd_n = 1'b0; romen_n = 1'b0; end
      K_RAMRD: begin mreq_n = 1'b0; rd_n = 1'b0; ramen_n = 1'b0; end
      K_RAMWR: begin mreq_n = 1'b0; wr_n = 1'b0; ramen_n = 1'b0; tbDrive = 1'b1; tbData = wdata; end
      K_IORD:  begin iorq_n = 1'b0; rd_n = 1'b0; end
      K_IOWR:  begin iorq_n = 1'b0; wr_n = 1'b0; tbDrive = 1'b1; tbData = wdata; end
      K_RFSH:  begin mreq_n = 1'b0; rfsh_n = 1'b0; romen_n = 1'b0; end
      K_INTA:  begin m1_n = 1'b0; iorq_n = 1'b0; end
      default: ;
    endcase
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #2;
      if (i == 0) tbData = ~tbData;
    end
    applyIdle();
    @(posedge clk); #2;
  endtask

  task automatic applyStimulus(input int kind, input logic [7:0] addr, input logic [7:0] wdata,
                               input int hold, input int expWait, input bit hasData,
                               input logic [7:0] expData);
    waitQ.push_back(expWait);
    if (hasData) dataQ.push_back(expData);
    busCycle(kind, addr, wdata, hold);
  endtask

  // Monitor: a bus cycle spans the negedges where mreq_n or iorq_n is low
  always @(negedge clk) begin
    if (!reset) begin
      inWin  = 1'b0;
      lowCnt = 0;
      seenRd = 1'b0;
    end else if (!mreq_n || !iorq_n) begin
      inWin = 1'b1;
      if (!wait_n) lowCnt++;
      if (!iorq_n && !rd_n && m1_n) begin
        seenRd = 1'b1;
        rdVal  = data;
      end
    end else if (inWin) begin
      if (waitQ.size() == 0) begin
        nCompared++;
        nFailed++;
        $display("[TB] FAIL waitCycles: got %0d, expected no bus cycle", lowCnt);
      end else begin
        checkOutput("waitCycles", lowCnt, waitQ.pop_front());
      end
      if (seenRd) begin
        if (dataQ.size() == 0) begin
          nCompared++;
          nFailed++;
          $display("[TB] FAIL readData: got %02h, expected no read", rdVal);
        end else begin
          checkOutput("readData", {24'd0, rdVal}, {24'd0, dataQ.pop_front()});
        end
      end
      inWin  = 1'b0;
      lowCnt = 0;
      seenRd = 1'b0;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    applyIdle();
    reset = 1'b0;
    // ROM read already pending when reset releases must not stretch
    #2;
    mreq_n = 1'b0; rd_n = 1'b0; romen_n = 1'b0;
    waitQ.push_back(0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetWaitN", {31'd0, wait_n}, 32'd1);
    #1;
    reset = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    applyIdle();
    @(posedge clk); #2;

    applyStimulus(K_ROMRD, 8'h00, 8'h00, 10, 3, 1'b0, 8'h00);
    applyStimulus(K_IORD,  8'hD2, 8'h00, 10, 1, 1'b1, 8'h43);
    applyStimulus(K_IORD,  8'hD3, 8'h00, 10, 1, 1'b1, 8'hFF);
    applyStimulus(K_IOWR,  8'hD2, 8'h90, 10, 1, 1'b0, 8'h00);
    applyStimulus(K_RAMWR, 8'h10, 8'h5A, 10, 2, 1'b0, 8'h00);
    applyStimulus(K_ROMRD, 8'h20, 8'h00, 10, 0, 1'b0, 8'h00);
    applyStimulus(K_IORD,  8'h40, 8'h00, 10, 2, 1'b1, 8'hFF);
    applyStimulus(K_IORD,  8'hD2, 8'h00, 10, 2, 1'b1, 8'h90);
    applyStimulus(K_IOWR,  8'hD2, 8'hFF, 10, 2, 1'b0, 8'h00);
    applyStimulus(K_RFSH,  8'h30, 8'h00, 10, 0, 1'b0, 8'h00);
    applyStimulus(K_INTA,  8'hD2, 8'h00, 10, 0, 1'b0, 8'h00);
    applyStimulus(K_RAMRD, 8'h11, 8'h00, 10, 7, 1'b0, 8'h00);
    applyStimulus(K_IORD,  8'h40, 8'h00, 10, 3, 1'b1, 8'hFF);

    // Abort: bus released in the middle of a 7-clock ROM stretch
    applyStimulus(K_ROMRD, 8'h21, 8'h00, 3, 2, 1'b0, 8'h00);
    checkOutput("abortWaitN", {31'd0, wait_n}, 32'd1);
    applyStimulus(K_ROMRD, 8'h22, 8'h00, 10, 7, 1'b0, 8'h00);

    // Reset pulse during the second stretch clock of a ROM read
    @(posedge clk); #2;
    mreq_n = 1'b0; rd_n = 1'b0; romen_n = 1'b0;
    @(posedge clk);
    @(posedge clk); #3;
    checkOutput("preResetWaitN", {31'd0, wait_n}, 32'd0);
    reset = 1'b0;
    #1;
    checkOutput("asyncResetWaitN", {31'd0, wait_n}, 32'd1);
    applyIdle();
    @(posedge clk); #2;
    checkOutput("inResetWaitN", {31'd0, wait_n}, 32'd1);
    reset = 1'b1;
    applyStimulus(K_IORD,  8'hD2, 8'h00, 10, 1, 1'b1, 8'h43);
    applyStimulus(K_ROMRD, 8'h23, 8'h00, 10, 3, 1'b0, 8'h00);

    // Config write of ROM=0 while a 3-clock ROM stretch is running
    waitQ.push_back(3);
    @(posedge clk); #2;
    mreq_n = 1'b0; rd_n = 1'b0; romen_n = 1'b0; a07 = 8'h24;
    @(posedge clk); #2;
    rd_n = 1'b1; iorq_n = 1'b0; wr_n = 1'b0; a07 = 8'hD2; tbDrive = 1'b1; tbData = 8'h40;
    @(posedge clk); #2;
    iorq_n = 1'b1; wr_n = 1'b1; tbDrive = 1'b0; rd_n = 1'b0; a07 = 8'h24;
    repeat (8) @(posedge clk);
    #2;
    applyIdle();
    @(posedge clk); #2;
    applyStimulus(K_ROMRD, 8'h25, 8'h00, 10, 0, 1'b0, 8'h00);
    applyStimulus(K_IORD,  8'hD2, 8'h00, 10, 1, 1'b1, 8'h40);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("waitQueueDrained", waitQ.size(), 32'd0);
    checkOutput("dataQueueDrained", dataQ.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
    $finish;
  end

endmodule
